// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl: Simon Says game sequencer driving generator/display strobes, press checking, timeout and win/lose.
module simon_round_ctrl #(
  parameter int MAX_ROUNDS     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start_btn,
  output logic       o_gen_start,
  input  logic       i_gen_done,
  output logic       o_disp_start,
  input  logic       i_disp_done,
  input  logic       i_press_valid,
  input  logic [1:0] i_press_colour,
  output logic [3:0] o_seq_idx,
  input  logic [1:0] i_seq_colour,
  output logic [4:0] o_round_len,
  output logic [1:0] o_state_dbg,
  output logic       o_busy,
  output logic       o_win,
  output logic       o_lose
);
  typedef enum logic [2:0] {S_IDLE, S_GEN, S_DISP, S_INPUT, S_NEXT, S_WIN, S_LOSE} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]      MAX_RL  = 5'(MAX_ROUNDS);
  state_t r_state, w_next;
  logic r_start_q, r_armed, r_first;
  logic [TO_W-1:0] r_to;
  logic [4:0] r_round_len;
  logic [3:0] r_seq_idx;
  logic w_start_edge, w_match, w_last, w_timeout;
  // r_armed masks the first cycle after reset so a held start_btn cannot look like an edge
  assign w_start_edge = i_start_btn & ~r_start_q & r_armed;
  assign w_match      = i_press_colour == i_seq_colour;
  assign w_last       = {1'b0, r_seq_idx} == r_round_len - 5'd1;
  assign w_timeout    = r_to == TO_LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= w_next != r_state;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: w_next = w_start_edge ? S_GEN : r_state;
      S_GEN:   w_next = (i_gen_done && !r_first) ? S_DISP : S_GEN;
      S_DISP:  w_next = (i_disp_done && !r_first) ? S_INPUT : S_DISP;
      S_INPUT: w_next = i_press_valid ? (!w_match ? S_LOSE : w_last ? S_NEXT : S_INPUT)
                                      : (w_timeout ? S_LOSE : S_INPUT);
      S_NEXT:  w_next = r_round_len == MAX_RL ? S_WIN : S_DISP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_to        <= '0;
      r_round_len <= 5'd1;
      r_seq_idx   <= '0;
    end else begin
      r_start_q <= i_start_btn;
      r_armed   <= 1'b1;
      if ((r_state == S_IDLE || r_state == S_WIN || r_state == S_LOSE) && w_start_edge) begin
        r_round_len <= 5'd1;
        r_seq_idx   <= '0;
      end
      if (r_state == S_DISP && w_next == S_INPUT) begin
        r_seq_idx <= '0;
        r_to      <= '0;
      end
      if (r_state == S_INPUT) begin
        if (i_press_valid) begin
          r_to <= '0;
          if (w_match && !w_last) r_seq_idx <= r_seq_idx + 4'd1;
        end else if (!w_timeout) begin
          r_to <= r_to + TO_W'(1);
        end
      end
      if (r_state == S_NEXT && w_next == S_DISP) begin
        r_round_len <= r_round_len + 5'd1;
        r_seq_idx   <= '0;
      end
    end
  end
  always_comb begin
    o_gen_start  = r_state == S_GEN && r_first;
    o_disp_start = r_state == S_DISP && r_first;
    o_busy       = r_state == S_GEN || r_state == S_DISP || r_state == S_INPUT || r_state == S_NEXT;
    o_win        = r_state == S_WIN;
    o_lose       = r_state == S_LOSE;
    o_state_dbg  = r_state == S_DISP ? 2'b01 :
                   r_state == S_INPUT ? 2'b10 :
                   (r_state == S_NEXT || r_state == S_WIN || r_state == S_LOSE) ? 2'b11 : 2'b00;
    o_seq_idx    = r_seq_idx;
    o_round_len  = r_round_len;
  end
endmodule
